// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI-addressable RAM: frame layout, command codes
// and control states.
package spi_ram_pkg;

    localparam int unsigned FRAME_W = 10;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned CMD_MSB = 9;
    localparam int unsigned CMD_LSB = 8;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    // ST_HOLD: frame already consumed, waiting for rx_valid to drop
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/spi_ram_if.sv
// Frame/response bundle between the SPI slave (master side) and the RAM controller.
interface spi_ram_if;
    import spi_ram_pkg::*;

    logic [FRAME_W-1:0] din;
    logic               rx_valid;
    logic [DATA_W-1:0]  dout;
    logic               tx_valid;
    logic               seq_err;

    modport master (output din, rx_valid, input dout, tx_valid, seq_err);
    modport slave  (input din, rx_valid, output dout, tx_valid, seq_err);

endinterface

// File: rtl/spram_core.sv
// Single-port 8-bit RAM: synchronous write, registered synchronous read.
module spram_core #(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic                 re,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [7:0]           wdata,
    output logic [7:0]           rdata
);

    logic [7:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register doubles as the held output word, so it clears on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command decoder for SPI frames driving a single-port RAM; one command per
// rising edge of rx_valid.
module spi_ram_ctrl
    import spi_ram_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned ADDR_SIZE = 8
) (
    input  logic     clk,
    input  logic     rst,
    spi_ram_if.slave bus
);

    ctrl_state_e          state_q, state_d;
    logic                 accept;
    cmd_e                 cmd;
    logic [ADDR_SIZE-1:0] addr;
    logic [ADDR_SIZE-1:0] wr_addr, rd_addr, mem_addr;
    logic                 wr_addr_vld, rd_addr_vld;
    logic                 mem_we, mem_re;
    logic                 tx_valid_q, seq_err_q;
    logic [7:0]           rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        cmd      = cmd_e'(bus.din[CMD_MSB:CMD_LSB]);
        addr     = bus.din[ADDR_SIZE-1:0];
        case (state_q)
            ST_IDLE: begin
                if (bus.rx_valid) begin
                    accept  = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!bus.rx_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        mem_we   = accept && (cmd == CMD_WR_DATA) && wr_addr_vld;
        mem_re   = accept && (cmd == CMD_RD_DATA) && rd_addr_vld;
        mem_addr = (cmd == CMD_RD_DATA) ? rd_addr : wr_addr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr     <= '0;
            rd_addr     <= '0;
            wr_addr_vld <= 1'b0;
            rd_addr_vld <= 1'b0;
            tx_valid_q  <= 1'b0;
            seq_err_q   <= 1'b0;
        end else begin
            seq_err_q <= 1'b0;
            if (accept) begin
                tx_valid_q <= mem_re;
                case (cmd)
                    CMD_WR_ADDR: begin
                        wr_addr     <= addr;
                        wr_addr_vld <= 1'b1;
                    end
                    CMD_WR_DATA: begin
                        if (wr_addr_vld) wr_addr <= wr_addr + ADDR_SIZE'(1);
                        else             seq_err_q <= 1'b1;
                    end
                    CMD_RD_ADDR: begin
                        rd_addr     <= addr;
                        rd_addr_vld <= 1'b1;
                    end
                    CMD_RD_DATA: begin
                        if (rd_addr_vld) rd_addr <= rd_addr + ADDR_SIZE'(1);
                        else             seq_err_q <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    spram_core #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (mem_addr),
        .wdata (bus.din[7:0]),
        .rdata (rdata)
    );

    assign bus.dout     = rdata;
    assign bus.tx_valid = tx_valid_q;
    assign bus.seq_err  = seq_err_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed and randomized frame stimulus for spi_ram_ctrl, checked every cycle
// against a frame-level behavioural model.
module tb_spi_ram_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    spi_ram_if bus();

    spi_ram_ctrl #(
        .MEM_DEPTH (256),
        .ADDR_SIZE (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;

    // Model: -1 marks an unwritten location / unknown read word
    int m_mem [256];
    int m_wr, m_rd, m_dout;
    bit m_wv, m_rv, m_txv, m_err, m_rxq;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_wr = 0; m_rd = 0; m_wv = 0; m_rv = 0;
        m_dout = 0; m_txv = 0; m_err = 0; m_rxq = 0;
    endtask

    task automatic model_step();
        int  cmd;
        int  pl;
        bit  acc;
        cmd   = int'(bus.din[9:8]);
        pl    = int'(bus.din[7:0]);
        acc   = bus.rx_valid && !m_rxq;
        m_rxq = bus.rx_valid;
        m_err = 0;
        if (acc) begin
            m_txv = 0;
            case (cmd)
                0: begin m_wr = pl; m_wv = 1; end
                1: if (m_wv) begin m_mem[m_wr] = pl; m_wr = (m_wr + 1) % 256; end
                   else m_err = 1;
                2: begin m_rd = pl; m_rv = 1; end
                default: if (m_rv) begin
                             m_dout = m_mem[m_rd]; m_txv = 1; m_rd = (m_rd + 1) % 256;
                         end else m_err = 1;
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        @(negedge clk);
        check_eq("tx_valid", 32'(bus.tx_valid), 32'(m_txv));
        check_eq("seq_err", 32'(bus.seq_err), 32'(m_err));
        if (m_dout >= 0) check_eq("dout", 32'(bus.dout), 32'(m_dout));
    endtask

    task automatic send(input logic [9:0] frame, input int hi, input int lo);
        bus.din      = frame;
        bus.rx_valid = 1'b1;
        repeat (hi) tick();
        bus.rx_valid = 1'b0;
        repeat (lo) tick();
    endtask

    // Reset pulse strictly between clock edges; outputs must clear at once
    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        check_eq("arst_tx_valid", 32'(bus.tx_valid), 32'h0);
        check_eq("arst_dout", 32'(bus.dout), 32'h0);
        check_eq("arst_seq_err", 32'(bus.seq_err), 32'h0);
        model_reset();
        #1 rst = 1'b0;
        tick();
    endtask

    initial begin
        logic [1:0] rcmd;
        logic [7:0] rpl;

        for (int i = 0; i < 256; i++) m_mem[i] = -1;
        model_reset();
        bus.din      = '0;
        bus.rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_dout", 32'(bus.dout), 32'h0);
        check_eq("rst_tx_valid", 32'(bus.tx_valid), 32'h0);
        check_eq("rst_seq_err", 32'(bus.seq_err), 32'h0);
        rst = 1'b0;
        tick();

        // Write then read, held until the next frame
        send(10'h005, 1, 1);
        send(10'h1A5, 1, 1);
        send(10'h205, 1, 1);
        send(10'h300, 1, 3);
        check_eq("wtr_dout", 32'(bus.dout), 32'hA5);
        check_eq("wtr_tx_valid", 32'(bus.tx_valid), 32'h1);
        send(10'h011, 1, 1);
        check_eq("wtr_tx_clear", 32'(bus.tx_valid), 32'h0);

        // Auto-increment and wrap
        send(10'h0FF, 1, 1);
        send(10'h111, 1, 1);
        send(10'h122, 1, 1);
        send(10'h2FF, 1, 1);
        send(10'h300, 1, 1);
        check_eq("wrap_rd0", 32'(bus.dout), 32'h11);
        send(10'h300, 1, 1);
        check_eq("wrap_rd1", 32'(bus.dout), 32'h22);

        // Held rx_valid gives exactly one write
        send(10'h010, 1, 1);
        send(10'h1C3, 5, 1);
        check_eq("held_wr_addr", 32'(dut.wr_addr), 32'h11);
        send(10'h210, 1, 1);
        send(10'h300, 1, 1);
        check_eq("held_rd", 32'(bus.dout), 32'hC3);
        send(10'h300, 1, 1);

        // Sequencing errors after reset
        async_reset();
        bus.din = 10'h355; bus.rx_valid = 1'b1; tick();
        check_eq("seqerr_rd", 32'(bus.seq_err), 32'h1);
        bus.rx_valid = 1'b0; tick();
        check_eq("seqerr_rd_clr", 32'(bus.seq_err), 32'h0);
        bus.din = 10'h155; bus.rx_valid = 1'b1; tick();
        check_eq("seqerr_wr", 32'(bus.seq_err), 32'h1);
        bus.rx_valid = 1'b0; tick();
        check_eq("seqerr_tx_valid", 32'(bus.tx_valid), 32'h0);
        check_eq("seqerr_no_wr_addr", 32'(dut.wr_addr), 32'h0);

        // Async reset mid-read
        send(10'h205, 1, 1);
        send(10'h300, 1, 1);
        check_eq("pre_arst_tx", 32'(bus.tx_valid), 32'h1);
        async_reset();
        bus.din = 10'h300; bus.rx_valid = 1'b1; tick();
        check_eq("post_arst_seqerr", 32'(bus.seq_err), 32'h1);
        bus.rx_valid = 1'b0; tick();

        // rx_valid already high at reset release counts as a rising edge
        rst = 1'b1;
        bus.din = 10'h077; bus.rx_valid = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        bus.rx_valid = 1'b0;
        tick();
        check_eq("release_wr_addr", 32'(dut.wr_addr), 32'h77);
        send(10'h1AB, 1, 1);
        send(10'h277, 1, 1);
        send(10'h300, 1, 1);
        check_eq("release_rd", 32'(bus.dout), 32'hAB);

        // Randomized frames with varying hold/gap lengths and occasional resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 3) async_reset();
            rcmd = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) rpl = 8'(($urandom_range(0, 7) + 252) % 256);
            else                           rpl = 8'($urandom_range(0, 255));
            send({rcmd, rpl}, int'($urandom_range(1, 4)), int'($urandom_range(1, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
